// File: rtl/ex_muldiv_unit_if.sv
// Request/response bundle between the EXE stage and the iterative multiply/divide unit.
// The EXE stage drives the request side (master); the unit answers with status and result (slave).
interface ex_muldiv_unit_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    logic             start_i;
    logic [2:0]       op_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic [TAG_W-1:0] tag_i;
    logic             flush_i;
    logic             busy_o;
    logic             stall_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic [TAG_W-1:0] tag_o;

    modport master (
        output start_i, op_i, src1_i, src2_i, tag_i, flush_i,
        input  busy_o, stall_o, done_o, result_o, tag_o
    );

    modport slave (
        input  start_i, op_i, src1_i, src2_i, tag_i, flush_i,
        output busy_o, stall_o, done_o, result_o, tag_o
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M-style multiply/divide unit for the EXE stage.
// One op at a time: shift-add multiply or restoring divide on operand magnitudes,
// one bit per cycle, sign correction applied when the result is presented.
// Divide-by-zero and signed overflow skip the iteration and finish on the next cycle.
module ex_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    ex_muldiv_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [2:0]         op_q;
    logic [TAG_W-1:0]   tag_q;
    logic [WIDTH-1:0]   a_q;
    logic [2*WIDTH-1:0] prod_q;
    logic               sign1_q;
    logic               sign2_q;
    logic               special_q;
    logic [WIDTH-1:0]   result_q;
    logic [TAG_W-1:0]   tag_out_q;

    logic               accept;
    logic               is_div;
    logic               signed1;
    logic               signed2;
    logic               sign1;
    logic               sign2;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic               div_zero;
    logic               div_ovf;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;

    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quot_fixed;
    logic [WIDTH-1:0]   rem_fixed;
    logic [WIDTH-1:0]   final_result;

    // Decode the incoming request: which operands are signed, their magnitudes, and the fast-path cases.
    always_comb begin
        accept   = (state_q == IDLE) && bus.start_i && !bus.flush_i;
        is_div   = bus.op_i[2];
        signed1  = (bus.op_i == OP_MULH) || (bus.op_i == OP_MULHSU) ||
                   (bus.op_i == OP_DIV)  || (bus.op_i == OP_REM);
        signed2  = (bus.op_i == OP_MULH) || (bus.op_i == OP_DIV) || (bus.op_i == OP_REM);
        sign1    = signed1 && bus.src1_i[WIDTH-1];
        sign2    = signed2 && bus.src2_i[WIDTH-1];
        mag1     = sign1 ? (~bus.src1_i + 1'b1) : bus.src1_i;
        mag2     = sign2 ? (~bus.src2_i + 1'b1) : bus.src2_i;
        div_zero = is_div && (bus.src2_i == '0);
        div_ovf  = ((bus.op_i == OP_DIV) || (bus.op_i == OP_REM)) &&
                   (bus.src1_i == MIN_NEG) && (bus.src2_i == '1);
    end

    // One iteration step for each algorithm; the CALC state picks the one matching the latched op.
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
        mul_next  = {mul_sum, prod_q[WIDTH-1:1]};
        rem_shift = prod_q[2*WIDTH-1:WIDTH-1];
        div_diff  = rem_shift - {1'b0, a_q};
        if (!div_diff[WIDTH]) begin
            div_next = {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {rem_shift[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
        end
    end

    // Sign correction and result selection from the finished product/quotient/remainder register.
    always_comb begin
        prod_fixed = (sign1_q ^ sign2_q) ? (~prod_q + 1'b1) : prod_q;
        quot_fixed = prod_q[WIDTH-1:0];
        rem_fixed  = prod_q[2*WIDTH-1:WIDTH];
        if (!special_q) begin
            if (sign1_q ^ sign2_q) begin
                quot_fixed = ~prod_q[WIDTH-1:0] + 1'b1;
            end
            if (sign1_q) begin
                rem_fixed = ~prod_q[2*WIDTH-1:WIDTH] + 1'b1;
            end
        end
        case (op_q)
            OP_MUL:                     final_result = prod_fixed[WIDTH-1:0];
            OP_MULH, OP_MULHSU,
            OP_MULHU:                   final_result = prod_fixed[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:            final_result = quot_fixed;
            OP_REM, OP_REMU:            final_result = rem_fixed;
            default:                    final_result = '0;
        endcase
    end

    // FSM state and iteration counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; a flush returns to IDLE from anywhere and wins over a new request.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (div_zero || div_ovf) ? DONE : CALC;
                    cnt_d   = '0;
                end
            end
            CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (bus.flush_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // Datapath: latch the request, iterate in CALC, and keep the last delivered result/tag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q      <= '0;
            tag_q     <= '0;
            a_q       <= '0;
            prod_q    <= '0;
            sign1_q   <= 1'b0;
            sign2_q   <= 1'b0;
            special_q <= 1'b0;
            result_q  <= '0;
            tag_out_q <= '0;
        end else if (accept) begin
            op_q      <= bus.op_i;
            tag_q     <= bus.tag_i;
            sign1_q   <= sign1;
            sign2_q   <= sign2;
            special_q <= div_zero || div_ovf;
            if (is_div) begin
                a_q    <= mag2;
                prod_q <= {{WIDTH{1'b0}}, mag1};
            end else begin
                a_q    <= mag1;
                prod_q <= {{WIDTH{1'b0}}, mag2};
            end
            if (div_zero) begin
                prod_q <= {bus.src1_i, {WIDTH{1'b1}}};
            end else if (div_ovf) begin
                prod_q <= {{WIDTH{1'b0}}, MIN_NEG};
            end
        end else if (state_q == CALC && !bus.flush_i) begin
            prod_q <= op_q[2] ? div_next : mul_next;
        end else if (state_q == DONE && !bus.flush_i) begin
            result_q  <= final_result;
            tag_out_q <= tag_q;
        end
    end

    // Status and result outputs; the result is presented directly in the DONE cycle.
    always_comb begin
        bus.busy_o   = (state_q != IDLE);
        bus.stall_o  = accept || (state_q == CALC);
        bus.done_o   = (state_q == DONE) && !bus.flush_i;
        bus.result_o = (state_q == DONE) ? final_result : result_q;
        bus.tag_o    = (state_q == DONE) ? tag_q : tag_out_q;
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit (WIDTH=32): directed cases, random ops against a
// 64-bit arithmetic reference model, plus flush, ignored-start and mid-op reset scenarios.
module tb_ex_muldiv_unit;
    localparam int WIDTH = 32;
    localparam int TAG_W = 5;
    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    logic clk;
    logic rst;

    ex_muldiv_unit_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    ex_muldiv_unit #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int done_pulses = 0;

    logic [31:0] res;
    logic [4:0]  rtag;
    int          lat;
    int          stalls;
    bit          pre_stall;
    bit          done_after;
    int          pulses_before;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every completion pulse, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.done_o === 1'b1) done_pulses++;
    end

    // Reference results straight from RV32M arithmetic on 64-bit integers.
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa;
        longint sb;
        longint ua;
        longint ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == MIN_NEG && b == 32'hFFFF_FFFF) return MIN_NEG;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Cycles from the accept edge to done_o: one for the divide special cases, WIDTH+1 otherwise.
    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (op[2] && b == 32'd0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == MIN_NEG && b == 32'hFFFF_FFFF) return 1;
        return WIDTH + 1;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    // Issue one op from IDLE and follow it to done_o, then step back into IDLE.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] tag, output logic [31:0] r_res,
                                 output logic [4:0] r_tag, output int r_lat, output int r_stalls,
                                 output bit r_pre_stall, output bit r_done_after);
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.src1_i  = a;
        bus.src2_i  = b;
        bus.tag_i   = tag;
        #1 r_pre_stall = bus.stall_o;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        r_lat    = 1;
        r_stalls = 0;
        while (bus.done_o !== 1'b1 && r_lat < 200) begin
            if (bus.stall_o === 1'b1) r_stalls++;
            @(posedge clk);
            #1 r_lat++;
        end
        r_res = bus.result_o;
        r_tag = bus.tag_o;
        @(posedge clk);
        #1 r_done_after = bus.done_o;
    endtask

    task automatic runCase(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] tag, input bit full);
        logic [31:0] c_res;
        logic [4:0]  c_tag;
        int          c_lat;
        int          c_stalls;
        bit          c_pre;
        bit          c_after;
        int          exp_lat;
        exp_lat = ref_latency(op, a, b);
        applyStimulus(op, a, b, tag, c_res, c_tag, c_lat, c_stalls, c_pre, c_after);
        checkOutput({name, " result"}, 64'(c_res), 64'(ref_result(op, a, b)));
        checkOutput({name, " tag"}, 64'(c_tag), 64'(tag));
        checkOutput({name, " latency"}, 64'(c_lat), 64'(exp_lat));
        if (full) begin
            checkOutput({name, " stall cycles"}, 64'(c_stalls), 64'(exp_lat - 1));
            checkOutput({name, " stall on accept"}, 64'(c_pre), 64'(1));
            checkOutput({name, " done one pulse"}, 64'(c_done_after_fix(c_after)), 64'(0));
        end
    endtask

    function automatic bit c_done_after_fix(input bit v);
        return v;
    endfunction

    initial begin
        bus.start_i = 1'b0;
        bus.op_i    = 3'd0;
        bus.src1_i  = '0;
        bus.src2_i  = '0;
        bus.tag_i   = '0;
        bus.flush_i = 1'b0;
        rst         = 1'b1;
        $display("[TB] reset");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busy", 64'(bus.busy_o), 64'(0));
        checkOutput("reset done", 64'(bus.done_o), 64'(0));
        checkOutput("reset stall", 64'(bus.stall_o), 64'(0));
        checkOutput("reset result", 64'(bus.result_o), 64'(0));
        checkOutput("reset tag", 64'(bus.tag_o), 64'(0));
        rst = 1'b0;

        $display("[TB] directed ops");
        runCase("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1);
        runCase("MULHU", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1'b0);
        runCase("MULH", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b0);
        runCase("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd8, 1'b0);
        runCase("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 1'b0);
        runCase("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 1'b0);
        runCase("DIVU 100/7", 3'd5, 32'd100, 32'd7, 5'd11, 1'b0);
        runCase("REMU 100/7", 3'd7, 32'd100, 32'd7, 5'd12, 1'b0);
        runCase("DIVU x/0", 3'd5, 32'h1234, 32'd0, 5'd13, 1'b1);
        runCase("REMU x/0", 3'd7, 32'h1234, 32'd0, 5'd14, 1'b0);
        runCase("DIV ovf", 3'd4, MIN_NEG, 32'hFFFF_FFFF, 5'd15, 1'b1);
        runCase("REM ovf", 3'd6, MIN_NEG, 32'hFFFF_FFFF, 5'd16, 1'b0);
        runCase("REM x/0 signed", 3'd6, 32'hFFFF_FF00, 32'd0, 5'd17, 1'b0);

        $display("[TB] random ops");
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  r_op;
            logic [31:0] r_a;
            logic [31:0] r_b;
            r_op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: r_a = 32'd0;
                1: r_a = 32'hFFFF_FFFF;
                2: r_a = MIN_NEG;
                3: r_a = 32'($urandom_range(0, 300));
                default: r_a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: r_b = 32'd0;
                1: r_b = 32'hFFFF_FFFF;
                2: r_b = MIN_NEG;
                3: r_b = 32'($urandom_range(1, 300));
                default: r_b = $urandom;
            endcase
            runCase($sformatf("rand%0d op%0d", i, r_op), r_op, r_a, r_b, 5'($urandom), 1'b0);
        end

        $display("[TB] flush and start together in IDLE");
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.flush_i = 1'b1;
        #1 checkOutput("flush beats start stall", 64'(bus.stall_o), 64'(0));
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        checkOutput("flush beats start busy", 64'(bus.busy_o), 64'(0));

        $display("[TB] flush during CALC");
        pulses_before = done_pulses;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = 3'd0;
        bus.src1_i  = 32'd1000;
        bus.src2_i  = 32'd3;
        bus.tag_i   = 5'd20;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        repeat (10) @(posedge clk);
        #1 bus.flush_i = 1'b1;
        @(posedge clk);
        #1 bus.flush_i = 1'b0;
        checkOutput("flush calc busy", 64'(bus.busy_o), 64'(0));
        checkOutput("flush calc done", 64'(bus.done_o), 64'(0));
        runCase("after flush DIVU", 3'd5, 32'd1000, 32'd3, 5'd21, 1'b1);
        checkOutput("flush calc pulses", 64'(done_pulses - pulses_before), 64'(1));

        $display("[TB] flush in DONE");
        pulses_before = done_pulses;
        res = bus.result_o;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = 3'd5;
        bus.src1_i  = 32'h55;
        bus.src2_i  = 32'd0;
        bus.tag_i   = 5'd22;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.flush_i = 1'b1;
        #1 checkOutput("flush done suppressed", 64'(bus.done_o), 64'(0));
        @(posedge clk);
        #1 bus.flush_i = 1'b0;
        checkOutput("flush done busy", 64'(bus.busy_o), 64'(0));
        checkOutput("flush done result held", 64'(bus.result_o), 64'(res));
        checkOutput("flush done pulses", 64'(done_pulses - pulses_before), 64'(0));

        $display("[TB] start during CALC ignored");
        pulses_before = done_pulses;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = 3'd0;
        bus.src1_i  = 32'd3;
        bus.src2_i  = 32'd5;
        bus.tag_i   = 5'd1;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.start_i = 1'b1;
        bus.op_i    = 3'd5;
        bus.src1_i  = 32'd9;
        bus.src2_i  = 32'd3;
        bus.tag_i   = 5'd2;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        checkOutput("ignored start pulses", 64'(done_pulses - pulses_before), 64'(1));
        checkOutput("ignored start result", 64'(bus.result_o), 64'(15));
        checkOutput("ignored start tag", 64'(bus.tag_o), 64'(1));
        checkOutput("ignored start idle", 64'(bus.busy_o), 64'(0));

        $display("[TB] reset during CALC");
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = 3'd4;
        bus.src1_i  = 32'd77;
        bus.src2_i  = 32'd5;
        bus.tag_i   = 5'd3;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        pulses_before = done_pulses;
        checkOutput("rst calc busy", 64'(bus.busy_o), 64'(0));
        checkOutput("rst calc done", 64'(bus.done_o), 64'(0));
        checkOutput("rst calc result", 64'(bus.result_o), 64'(0));
        checkOutput("rst calc tag", 64'(bus.tag_o), 64'(0));
        repeat (40) @(posedge clk);
        #1 checkOutput("rst calc no done", 64'(done_pulses - pulses_before), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
